// File: rtl/eth_preamble_strip.sv
// eth_preamble_strip
// Removes a fixed PREAMBLE_BYTES-long pad from the head of every frame on a
// 64-bit AXI-Stream and realigns the remaining bytes down to byte lane 0.
// A one-word holding register carries the upper bytes of the previous beat.
// When the tail of a frame does not fit in the realigned last beat, a FLUSH
// state emits one extra beat.
//
// Optional build macro: ETH_PREAMBLE_STRIP_STATS_EN
//   When it is defined, the saturating counters o_frame_cnt and o_runt_cnt
//   are added. The datapath behaves the same in both builds.
module eth_preamble_strip #(
  parameter int unsigned PREAMBLE_BYTES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] i_tdata,
  input  logic [7:0]  i_tkeep,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  output logic [63:0] o_tdata,
  output logic [7:0]  o_tkeep,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        o_runt
`ifdef ETH_PREAMBLE_STRIP_STATS_EN
  ,
  output logic [31:0] o_frame_cnt,
  output logic [15:0] o_runt_cnt
`endif
);

  // Elaboration-time range check on the strip length.
  if (PREAMBLE_BYTES > 7) begin : g_bad_preamble
    $error("eth_preamble_strip: PREAMBLE_BYTES must be in 0..7");
  end

  localparam int unsigned P   = PREAMBLE_BYTES;
  localparam int unsigned H   = (P <= 8) ? (8 - P) : 0;
  localparam int unsigned PSH = 8 * P;
  localparam int unsigned HSH = 8 * H;
  localparam logic [3:0]  P4  = 4'(P);
  localparam logic [3:0]  H4  = 4'(H);

  typedef enum logic [1:0] {
    ST_FIRST = 2'd0,
    ST_MID   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // When nothing is stripped, the block is a plain registered pipe that stays in MID.
  localparam state_e ST_RESET = (P == 0) ? ST_MID : ST_FIRST;

  // Returns a keep vector with the low n lanes set (n = 0..8).
  function automatic logic [7:0] keep_mask(input logic [3:0] n);
    logic [7:0] m;
    m = 8'h00;
    for (int b = 0; b < 8; b++) begin
      m[b] = (4'(b) < n);
    end
    return m;
  endfunction

  // Expands a byte keep vector into a 64-bit data mask.
  function automatic logic [63:0] lane_mask(input logic [7:0] keep);
    logic [63:0] m;
    m = 64'd0;
    for (int b = 0; b < 8; b++) begin
      m[8*b +: 8] = {8{keep[b]}};
    end
    return m;
  endfunction

  // Number of valid bytes in a beat. Malformed keep patterns, and every
  // non-last beat, count as a full beat.
  function automatic logic [3:0] beat_bytes(input logic [7:0] keep, input logic last);
    logic [3:0] n;
    n = 4'd8;
    if (last && (keep != 8'h00) && ((keep & (keep + 8'd1)) == 8'h00)) begin
      n = 4'd0;
      for (int b = 0; b < 8; b++) begin
        n = n + {3'd0, keep[b]};
      end
    end else begin
      n = 4'd8;
    end
    return n;
  endfunction

  state_e      state_q, state_d;
  logic [63:0] held_q, held_d;
  logic [3:0]  resid_q, resid_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;
  logic        runt_q, runt_d;

  logic        slot_free_s;
  logic        accept_s;
  logic [3:0]  k_s;
  logic [63:0] data_first_s;
  logic [63:0] data_mid_s;
  logic        emit_s;
  logic [63:0] emit_data_s;
  logic [3:0]  emit_cnt_s;
  logic        emit_last_s;
  logic [7:0]  emit_keep_s;

  assign slot_free_s  = !tvalid_q || o_tready;
  assign i_tready     = slot_free_s && (state_q != ST_FLUSH);
  assign accept_s     = i_tvalid && i_tready;
  assign k_s          = beat_bytes(i_tkeep, i_tlast);
  // Bytes past the preamble, moved down to lane 0.
  assign data_first_s = i_tdata >> PSH;
  // Held bytes in the low lanes, followed by the head of the current beat.
  assign data_mid_s   = held_q | (i_tdata << HSH);

  // Next-state logic: FSM transitions, holding register update and output beat build.
  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    resid_d     = resid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    runt_d      = 1'b0;
    emit_s      = 1'b0;
    emit_data_s = 64'd0;
    emit_cnt_s  = 4'd0;
    emit_last_s = 1'b0;
    emit_keep_s = 8'h00;

    // Once the current beat has been taken, the output slot empties unless it is refilled below.
    if (slot_free_s) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    case (state_q)
      ST_FIRST: begin
        if (accept_s) begin
          if (i_tlast) begin
            if (k_s <= P4) begin
              runt_d = 1'b1;
            end else begin
              emit_s      = 1'b1;
              emit_data_s = data_first_s;
              emit_cnt_s  = k_s - P4;
              emit_last_s = 1'b1;
            end
          end else begin
            held_d  = data_first_s;
            state_d = ST_MID;
          end
        end else begin
          state_d = ST_FIRST;
        end
      end

      ST_MID: begin
        if (accept_s) begin
          held_d = data_first_s;
          emit_s = 1'b1;
          if (P == 0) begin
            emit_data_s = i_tdata;
            emit_cnt_s  = k_s;
            emit_last_s = i_tlast;
          end else begin
            emit_data_s = data_mid_s;
            if (i_tlast && (k_s <= P4)) begin
              emit_cnt_s  = H4 + k_s;
              emit_last_s = 1'b1;
              state_d     = ST_FIRST;
            end else if (i_tlast) begin
              // The tail spills past this beat; its bytes stay in held_d for FLUSH.
              emit_cnt_s  = 4'd8;
              emit_last_s = 1'b0;
              resid_d     = k_s - P4;
              state_d     = ST_FLUSH;
            end else begin
              emit_cnt_s  = 4'd8;
              emit_last_s = 1'b0;
            end
          end
        end else begin
          state_d = ST_MID;
        end
      end

      ST_FLUSH: begin
        if (slot_free_s) begin
          emit_s      = 1'b1;
          emit_data_s = held_q;
          emit_cnt_s  = resid_q;
          emit_last_s = 1'b1;
          state_d     = ST_FIRST;
        end else begin
          state_d = ST_FLUSH;
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase

    if (emit_s) begin
      emit_keep_s = keep_mask(emit_cnt_s);
      tvalid_d    = 1'b1;
      tkeep_d     = emit_keep_s;
      tdata_d     = emit_data_s & lane_mask(emit_keep_s);
      tlast_d     = emit_last_s;
    end else begin
      emit_keep_s = 8'h00;
    end
  end

  // State, holding register and registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RESET;
      held_q   <= 64'd0;
      resid_q  <= 4'd0;
      tdata_q  <= 64'd0;
      tkeep_q  <= 8'h00;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      runt_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      resid_q  <= resid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      runt_q   <= runt_d;
    end
  end

  assign o_tdata  = tdata_q;
  assign o_tkeep  = tkeep_q;
  assign o_tlast  = tlast_q;
  assign o_tvalid = tvalid_q;
  assign o_runt   = runt_q;

`ifdef ETH_PREAMBLE_STRIP_STATS_EN
  logic [31:0] frame_cnt_q;
  logic [15:0] runt_cnt_q;

  // Saturating counters: delivered frames (last beat accepted) and dropped runts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 32'd0;
      runt_cnt_q  <= 16'd0;
    end else begin
      if (tvalid_q && o_tready && tlast_q && (frame_cnt_q != 32'hFFFF_FFFF)) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end else begin
        frame_cnt_q <= frame_cnt_q;
      end
      if (runt_q && (runt_cnt_q != 16'hFFFF)) begin
        runt_cnt_q <= runt_cnt_q + 16'd1;
      end else begin
        runt_cnt_q <= runt_cnt_q;
      end
    end
  end

  assign o_frame_cnt = frame_cnt_q;
  assign o_runt_cnt  = runt_cnt_q;
`endif

endmodule

// File: doc/eth_preamble_strip.md
# eth_preamble_strip

Streaming realigner between the 10GbE MAC receive path and `eth_ifc` on 64-bit interfaces. It removes a fixed-length pad/preamble, `PREAMBLE_BYTES` long, from the head of every frame and shifts the remaining bytes down to byte lane 0. This lets `eth_ifc` instances built for a zero-preamble stream be fed by MACs that prepend 6 alignment bytes. The datapath is a one-word holding register plus a small FSM that emits an extra flush beat when the tail spills.

## Interface
- `PREAMBLE_BYTES`, 6, bytes stripped from each frame head; legal range 0..7, elaboration error otherwise.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_tdata`  in  64  input data; byte 0 (first on wire) is `[7:0]`.
- `i_tkeep`  in  8  byte enables, contiguous from LSB; all-ones on non-last beats.
- `i_tlast`  in  1  last beat of frame.
- `i_tvalid`  in  1  input valid.
- `i_tready`  out  1  input ready.
- `o_tdata`  out  64  realigned data.
- `o_tkeep`  out  8  realigned byte enables.
- `o_tlast`  out  1  last beat of realigned frame.
- `o_tvalid`  out  1  output valid.
- `o_tready`  in  1  output ready.
- `o_runt`  out  1  one-cycle pulse when a frame is dropped for having no payload.

## Operation
- Definitions:
  - P = `PREAMBLE_BYTES`; H = 8-P.
  - `held` = upper H bytes of the previous input beat.
  - K = number of set bits in `i_tkeep` on a last beat.
- States:
  - FIRST: accept beat 0 into `held`; emit nothing. If that beat is last: K<=P → drop the frame, pulse `o_runt`, stay in FIRST; K>P → emit one beat holding K-P bytes with `o_tlast`, stay in FIRST. Otherwise go to MID.
  - MID: each accepted beat emits `{i_tdata[8P-1:0], held}` and updates `held`. On a non-last beat the output keep is all-ones. On a last beat with K<=P, emit keep for H+K bytes with `o_tlast` and go to FIRST. On a last beat with K>P, emit a full beat without last, store the residue, and go to FLUSH.
  - FLUSH: `i_tready`=0; emit `held` with K-P bytes set in keep and `o_tlast`=1, then go to FIRST.
- P=0: pure one-beat registered passthrough; FSM stays in MID; `o_runt` is never asserted.
- A non-contiguous `i_tkeep`, or a non-all-ones keep on a non-last beat, is treated as all-ones. Behaviour is defined, but the data is not protected.
- Unused output byte lanes are driven to zero.

## Timing
- Output is registered.
  - `i_tready` = (`o_tvalid`=0 or `o_tready`=1) and state≠FLUSH.
- Latency: output beat n appears the cycle after input beat n+1 is accepted (first-beat latency is 2 accepted beats). For P=0 latency is 1 cycle.
- Full throughput of one beat per cycle in MID. The only bubble is one input stall cycle per FLUSH.
- AXI-Stream rules:
  - `o_tvalid` holds, with data stable, until `o_tready`.
  - No combinational path from `o_tready` to `o_tvalid`.
  - `i_tready` is combinational from `o_tready`.
- Back-to-back frames: the first beat of frame N+1 may be accepted in the cycle after the last beat of frame N leaves MID or FLUSH.
- Reset values:
  - `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `o_tkeep`=0, `o_runt`=0.
  - State is FIRST.
  - `i_tready`=1 once reset deasserts.
- Reset mid-frame discards the held and pending beats. The downstream block sees no `o_tlast` for the truncated frame and must be reset alongside.

## Configuration
- `ETH_PREAMBLE_STRIP_STATS_EN` defined: adds outputs `o_frame_cnt` [31:0] and `o_runt_cnt` [15:0].
  - `o_frame_cnt` increments on every accepted output beat with `o_tlast`.
  - `o_runt_cnt` increments on every `o_runt` pulse.
  - Both saturate at all-ones, reset to 0 asynchronously, and are cleared by no other means.
- Undefined: neither port exists and no counter logic is built. Datapath behaviour is identical in both builds.

## Test plan
- P=6, 3-beat frame, bytes 0x00..0x17 with the last beat K=8: outputs are {0x06..0x0D}, {0x0E..0x15} with keep FF, then {0x16,0x17} with keep 0x03 and last, emitted from FLUSH. `i_tready` is low exactly 1 cycle.
- P=6, 2-beat frame, last K=4: a single output beat with bytes 0x06..0x0B, keep 0x3F, last, and no FLUSH.
- P=6, 1-beat frame, K=5: frame dropped, `o_runt` pulses once, no output. The same case with K=8 gives one beat, keep 0x03, last.
- Random `o_tready` (50%) over 1000 frames, lengths 1..1500 bytes, compared against a byte-queue model: every payload byte is in order, there are no extra beats, and `o_tdata` is stable while stalled.
- Assert `rst_n` low between beats 2 and 3 of a frame: all outputs are 0 immediately. After release, the next frame realigns correctly.
- P=0: output equals input delayed by 1 cycle under full throughput. With the stats macro defined, `o_frame_cnt` equals the number of frames sent.
